// File: rtl/fetch_buffer.sv
// Instruction-fetch stage: issues PC-addressed requests to instruction memory,
// queues {pc, instruction} pairs for the decoder and steers the program counter.
module fetch_buffer #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [ADDR_W-1:0] pc_value,
  output logic [ADDR_W-1:0] pc_start_value,
  output logic              pc_load,
  output logic              pc_count_up,
  output logic              pc_hold,
  output logic              pc_enable,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_ACK = 2'd1;
  localparam logic [1:0] PC_UPD   = 2'd2;
  localparam logic [1:0] DRAIN    = 2'd3;

  logic [1:0]        state;
  logic [PTR_W:0]    count;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic [ADDR_W-1:0] fifo_pc   [DEPTH];
  logic              fifo_full;
  logic              push;
  logic              pop;

  assign fifo_full   = (count == FULL_COUNT);
  assign push        = (state == WAIT_ACK) & mem_ack & ~branch_taken;
  assign instr_valid = (count != '0) & ~branch_taken;
  assign pop         = instr_valid & instr_ready;
  assign instr_data  = fifo_data[rd_ptr];
  assign instr_pc    = fifo_pc[rd_ptr];

  assign pc_enable = pc_load | pc_count_up;
  assign pc_hold   = ~pc_enable;

  // mem_req is high exactly while a request is outstanding (WAIT_ACK or DRAIN),
  // so it doubles as the "outstanding" flag for the redirect decision.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      mem_req        <= 1'b0;
      mem_addr       <= '0;
      pc_start_value <= '0;
      pc_load        <= 1'b0;
      pc_count_up    <= 1'b0;
    end else begin
      pc_load     <= 1'b0;
      pc_count_up <= 1'b0;
      if (branch_taken) begin
        pc_load        <= 1'b1;
        pc_start_value <= branch_target;
        if (mem_req && !mem_ack) begin
          state <= DRAIN;
        end else begin
          state   <= PC_UPD;
          mem_req <= 1'b0;
        end
      end else begin
        case (state)
          IDLE: begin
            if (enable && !fifo_full) begin
              mem_req  <= 1'b1;
              mem_addr <= pc_value;
              state    <= WAIT_ACK;
            end
          end
          WAIT_ACK: begin
            if (mem_ack) begin
              mem_req        <= 1'b0;
              pc_start_value <= mem_addr;
              pc_count_up    <= 1'b1;
              state          <= PC_UPD;
            end
          end
          PC_UPD: state <= IDLE;
          DRAIN: begin
            if (mem_ack) begin
              mem_req <= 1'b0;
              state   <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Instruction queue; a redirect flushes it at the same edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_pc[i]   <= '0;
      end
    end else if (branch_taken) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= mem_rdata;
        fifo_pc[wr_ptr]   <= mem_addr;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer with a small PC counter model and memory responder.
module tb_fetch_buffer;

  logic        clock;
  logic        reset;
  logic        enable;
  logic [3:0]  pc_value;
  logic [3:0]  pc_start_value;
  logic        pc_load;
  logic        pc_count_up;
  logic        pc_hold;
  logic        pc_enable;
  logic        mem_req;
  logic [3:0]  mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        branch_taken;
  logic [3:0]  branch_target;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [3:0]  instr_pc;

  int n_checks = 0;
  int n_bad    = 0;
  bit auto_mem;
  int lat;
  int wait_cnt;

  fetch_buffer #(.ADDR_W(4), .DATA_W(32), .DEPTH(4)) dut (
    .clock(clock), .reset(reset), .enable(enable), .pc_value(pc_value),
    .pc_start_value(pc_start_value), .pc_load(pc_load), .pc_count_up(pc_count_up),
    .pc_hold(pc_hold), .pc_enable(pc_enable), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .branch_taken(branch_taken),
    .branch_target(branch_target), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Counter model: resets to 1, loads on pc_load, increments on pc_count_up.
  always @(posedge clock or posedge reset) begin
    if (reset)
      pc_value <= 4'h1;
    else if (pc_enable && pc_load)
      pc_value <= pc_start_value;
    else if (pc_enable && pc_count_up)
      pc_value <= pc_value + 4'h1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock; then the responder raises a one-cycle ack after 'lat' stall cycles.
  task automatic step();
    @(posedge clock);
    #1;
    if (auto_mem) begin
      if (mem_ack) begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end else if (mem_req) begin
        if (wait_cnt == lat) begin
          mem_ack   = 1'b1;
          mem_rdata = 32'hE3A00000 | {28'h0, mem_addr};
        end else begin
          wait_cnt++;
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; enable = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    branch_taken = 1'b0; branch_target = '0; instr_ready = 1'b0;
    auto_mem = 1'b1; lat = 0; wait_cnt = 0;

    #12;
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_pc_hold", pc_hold, 1);
    check("rst_pc_enable", pc_enable, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_start", pc_start_value, 0);
    reset = 1'b0;

    // First fetch, 1-cycle memory
    step();
    enable = 1'b1;
    step();
    check("t1_req", mem_req, 1);
    check("t1_addr", mem_addr, 4'h1);
    step();
    check("t1_count_up", pc_count_up, 1);
    check("t1_load", pc_load, 0);
    check("t1_start", pc_start_value, 4'h1);
    check("t1_hold", pc_hold, 0);
    check("t1_req_drop", mem_req, 0);
    check("t1_valid", instr_valid, 1);
    check("t1_head_pc", instr_pc, 4'h1);
    check("t1_head_data", instr_data, 32'hE3A00001);
    step();
    check("t1_count_up_pulse", pc_count_up, 0);
    check("t1_hold_back", pc_hold, 1);

    // Fill the FIFO with decoder stalled
    repeat (20) step();
    check("t2_full_no_req", mem_req, 0);
    check("t2_head_pc", instr_pc, 4'h1);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    check("t2_head_after_pop", instr_pc, 4'h2);
    step();
    check("t2_refill_req", mem_req, 1);
    check("t2_refill_addr", mem_addr, 4'h5);
    enable = 1'b0;
    step();
    step();
    for (int k = 2; k <= 5; k++) begin
      check("t2_order_pc", instr_pc, k);
      check("t2_order_data", instr_data, 32'hE3A00000 | k);
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
    end
    check("t2_empty", instr_valid, 0);

    // Slow memory: 5 stall cycles
    lat = 5;
    enable = 1'b1;
    step();
    enable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("t3_req_stable", mem_req, 1);
      check("t3_addr_stable", mem_addr, 4'h6);
      check("t3_no_count_up", pc_count_up, 0);
      step();
    end
    check("t3_count_up", pc_count_up, 1);
    check("t3_start", pc_start_value, 4'h6);
    step();
    step();
    lat = 0;
    enable = 1'b1;
    step();
    step();
    step();
    enable = 1'b0;

    // Redirect while waiting with two entries queued
    lat = 5;
    enable = 1'b1;
    step();
    enable = 1'b0;
    check("t4_wait_addr", mem_addr, 4'h8);
    check("t4_valid_before", instr_valid, 1);
    check("t4_head_before", instr_pc, 4'h6);
    branch_taken = 1'b1;
    branch_target = 4'hA;
    #1;
    check("t4_valid_masked", instr_valid, 0);
    step();
    branch_taken = 1'b0;
    check("t4_load", pc_load, 1);
    check("t4_load_start", pc_start_value, 4'hA);
    check("t4_no_count_up", pc_count_up, 0);
    check("t4_drain_req", mem_req, 1);
    check("t4_drain_addr", mem_addr, 4'h8);
    check("t4_flushed", instr_valid, 0);
    for (int i = 0; i < 20; i++) begin
      if (!mem_req) break;
      step();
    end
    check("t4_drain_done", mem_req, 0);
    check("t4_ack_discarded", instr_valid, 0);
    check("t4_drain_no_count_up", pc_count_up, 0);
    lat = 0;
    enable = 1'b1;
    step();
    enable = 1'b0;
    check("t4_next_req", mem_req, 1);
    check("t4_next_addr", mem_addr, 4'hA);
    step();
    step();
    check("t4_head_pc", instr_pc, 4'hA);
    check("t4_head_data", instr_data, 32'hE3A0000A);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    check("t4_popped", instr_valid, 0);

    // Branch coinciding with ack
    auto_mem = 1'b0;
    enable = 1'b1;
    step();
    enable = 1'b0;
    check("t5_req_addr", mem_addr, 4'hB);
    mem_ack = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    branch_taken = 1'b1;
    branch_target = 4'h3;
    step();
    mem_ack = 1'b0;
    branch_taken = 1'b0;
    check("t5_load", pc_load, 1);
    check("t5_no_count_up", pc_count_up, 0);
    check("t5_start", pc_start_value, 4'h3);
    check("t5_no_drain", mem_req, 0);
    check("t5_no_push", instr_valid, 0);
    step();
    check("t5_load_pulse", pc_load, 0);
    check("t5_idle_req", mem_req, 0);
    enable = 1'b1;
    step();
    enable = 1'b0;
    check("t5_next_req", mem_req, 1);
    check("t5_next_addr", mem_addr, 4'h3);

    // Asynchronous reset in WAIT_ACK, then a stray ack
    #3;
    reset = 1'b1;
    #1;
    check("t6_req_async", mem_req, 0);
    check("t6_addr_async", mem_addr, 0);
    check("t6_hold_async", pc_hold, 1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'h12345678;
    step();
    mem_ack = 1'b0;
    check("t6_late_ack_no_push", instr_valid, 0);
    check("t6_late_ack_no_count", pc_count_up, 0);
    check("t6_late_ack_no_req", mem_req, 0);

    // Address wrap F -> 0
    auto_mem = 1'b1;
    branch_taken = 1'b1;
    branch_target = 4'hF;
    step();
    branch_taken = 1'b0;
    check("t7_load_f", pc_start_value, 4'hF);
    step();
    enable = 1'b1;
    step();
    check("t7_addr_f", mem_addr, 4'hF);
    step();
    step();
    step();
    enable = 1'b0;
    check("t7_wrap_req", mem_req, 1);
    check("t7_wrap_addr", mem_addr, 4'h0);
    check("t7_head_f", instr_pc, 4'hF);
    step();
    step();

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
